// File: rtl/tristate_bus_pkg.sv
// rtl/tristate_bus_pkg.sv - shared types, defaults and width helper for the tristate bus arbiter
package tristate_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_MAX_HOLD = 16;
  localparam int DEF_TURN_CYC = 1;

  // Width needed to count/index 0..n-1, never below one bit
  function automatic int idx_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner search starting at ptr
module rr_picker
  import tristate_bus_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = idx_width(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest request to ptr is left as the winner
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr) + i) % N_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// rtl/tristate_bus_arbiter.sv - round-robin tristate bus owner with turnaround gap and hold limit
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int TURN_CYC = DEF_TURN_CYC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         oe,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     bus_idle,
  output logic                     hold_timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = idx_width(MAX_HOLD);
  localparam int TW = idx_width(TURN_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

  state_e          state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]   turn_cnt_q, turn_cnt_d;
  logic            hold_timeout_q, hold_timeout_d;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            owner_done;
  logic            owner_drop;
  logic            hold_hit;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_picker (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_done = done[owner_q];
  assign owner_drop = ~req[owner_q];
  assign hold_hit   = (hold_cnt_q == HOLD_LAST);

  // Next-state logic: arbitrate in IDLE, count hold in DRIVE, enforce dead time in TURN
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    owner_d        = owner_q;
    ptr_d          = ptr_q;
    hold_cnt_d     = hold_cnt_q;
    turn_cnt_d     = turn_cnt_q;
    hold_timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          state_d           = ST_DRIVE;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          ptr_d             = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          hold_cnt_d        = '0;
        end
      end
      ST_DRIVE: begin
        if (owner_done || owner_drop || hold_hit) begin
          // Release always goes through TURN; a voluntary release masks the timeout pulse
          state_d        = ST_TURN;
          grant_d        = '0;
          turn_cnt_d     = '0;
          hold_timeout_d = hold_hit & ~owner_done & ~owner_drop;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_TURN: begin
        grant_d = '0;
        if (turn_cnt_q == TURN_LAST) begin
          state_d = ST_IDLE;
        end else begin
          turn_cnt_d = turn_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers; reset releases the bus on the very next edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      owner_q        <= '0;
      ptr_q          <= '0;
      hold_cnt_q     <= '0;
      turn_cnt_q     <= '0;
      hold_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      owner_q        <= owner_d;
      ptr_q          <= ptr_d;
      hold_cnt_q     <= hold_cnt_d;
      turn_cnt_q     <= turn_cnt_d;
      hold_timeout_q <= hold_timeout_d;
    end
  end

  assign grant        = grant_q;
  assign oe           = grant_q;
  assign owner        = owner_q;
  assign bus_idle     = ~|grant_q;
  assign hold_timeout = hold_timeout_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb/tb_tristate_bus_arbiter.sv - self-checking bench for tristate_bus_arbiter
module tb_tristate_bus_arbiter;

  localparam int N_REQ    = 4;
  localparam int MAX_HOLD = 16;
  localparam int TURN_CYC = 1;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic [3:0] oe;
  logic [1:0] owner;
  logic       bus_idle;
  logic       hold_timeout;

  int checks;
  int errors;
  int tmo_cnt;
  bit sb_en;
  logic [3:0] exp_q[$];

  tristate_bus_arbiter #(
    .N_REQ    (N_REQ),
    .MAX_HOLD (MAX_HOLD),
    .TURN_CYC (TURN_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .done         (done),
    .grant        (grant),
    .oe           (oe),
    .owner        (owner),
    .bus_idle     (bus_idle),
    .hold_timeout (hold_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle monitor: invariants every cycle, grant order against the scoreboard queue
  initial begin : monitor
    logic [3:0] prev_oe;
    logic [3:0] e;
    int run_len;
    prev_oe = 4'b0000;
    run_len = 0;
    forever begin
      @(negedge clk);
      checks++;
      if (grant !== oe) begin
        errors++;
        $display("FAIL grant_eq_oe grant=%b oe=%b", grant, oe);
      end
      checks++;
      if (!$onehot0(oe)) begin
        errors++;
        $display("FAIL onehot0 oe=%b required at most one bit", oe);
      end
      checks++;
      if (bus_idle !== (oe == 4'b0000)) begin
        errors++;
        $display("FAIL bus_idle got=%b oe=%b", bus_idle, oe);
      end
      checks++;
      if (prev_oe != 4'b0000 && oe != 4'b0000 && oe != prev_oe) begin
        errors++;
        $display("FAIL direct_switch oe %b -> %b required a zero cycle", prev_oe, oe);
      end
      if (oe != 4'b0000) begin
        checks++;
        if (oe !== (4'b0001 << owner)) begin
          errors++;
          $display("FAIL owner_match owner=%0d oe=%b", owner, oe);
        end
        run_len = (oe == prev_oe) ? run_len + 1 : 1;
        checks++;
        if (run_len > MAX_HOLD) begin
          errors++;
          $display("FAIL hold_limit run=%0d max=%0d", run_len, MAX_HOLD);
        end
      end else begin
        run_len = 0;
      end
      if (hold_timeout === 1'b1) tmo_cnt++;
      if (sb_en && oe != 4'b0000 && prev_oe == 4'b0000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got=%b required no grant", oe);
        end else begin
          e = exp_q.pop_front();
          if (oe !== e) begin
            errors++;
            $display("FAIL sb_grant got=%b required=%b", oe, e);
          end
        end
      end
      prev_oe = oe;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 4'b0000;
    tick();
    rst  = 1'b0;
    exp_q.delete();
    tmo_cnt = 0;
  endtask

  task automatic drain();
    req  = 4'b0000;
    done = 4'b0000;
    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d grants missing required=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 4'b0000;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0000 || oe !== 4'b0000 || owner !== 2'd0 || bus_idle !== 1'b1 || hold_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state grant=%b oe=%b owner=%0d idle=%b tmo=%b", grant, oe, owner, bus_idle, hold_timeout);
    end
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0100);
    req = 4'b0100;
    tick();
    checks++;
    if (oe !== 4'b0100 || owner !== 2'd2) begin
      errors++;
      $display("FAIL reset_pre_drive oe=%b owner=%0d required oe=0100 owner=2", oe, owner);
    end
    rst = 1'b1;
    req = 4'b1100;
    tick();
    checks++;
    if (oe !== 4'b0000 || bus_idle !== 1'b1 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_drive oe=%b idle=%b owner=%0d required 0000/1/0", oe, bus_idle, owner);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (oe !== 4'b0100) begin
      errors++;
      $display("FAIL reset_ptr_zero oe=%b required=0100", oe);
    end
    drain();
  endtask

  task automatic test_single();
    int gap;
    int n;
    do_reset();
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0001);
    req = 4'b0001;
    tick();
    checks++;
    if (oe !== 4'b0001) begin
      errors++;
      $display("FAIL single_latency oe=%b required=0001", oe);
    end
    tick();
    tick();
    done = 4'b0001;
    tick();
    done = 4'b0000;
    checks++;
    if (oe !== 4'b0000) begin
      errors++;
      $display("FAIL single_release oe=%b required=0000", oe);
    end
    gap = 1;
    n = 0;
    while (oe === 4'b0000 && n < 10) begin
      tick();
      if (oe === 4'b0000) gap++;
      n++;
    end
    checks++;
    if (gap != TURN_CYC + 1 || oe !== 4'b0001) begin
      errors++;
      $display("FAIL single_regrant gap=%0d oe=%b required gap=%0d oe=0001", gap, oe, TURN_CYC + 1);
    end
    drain();
    checks++;
    if (tmo_cnt != 0) begin
      errors++;
      $display("FAIL single_timeout pulses=%0d required=0", tmo_cnt);
    end
  endtask

  task automatic test_round_robin();
    int gap;
    int n;
    do_reset();
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    req = 4'b1111;
    tick();
    checks++;
    if (oe !== 4'b0001) begin
      errors++;
      $display("FAIL rr_first oe=%b required=0001", oe);
    end
    for (int g = 0; g < 5; g++) begin
      tick();
      done = oe;
      tick();
      done = 4'b0000;
      checks++;
      if (oe !== 4'b0000) begin
        errors++;
        $display("FAIL rr_release g=%0d oe=%b required=0000", g, oe);
      end
      if (g == 4) begin
        req = 4'b0000;
      end else begin
        gap = 1;
        n = 0;
        while (oe === 4'b0000 && n < 10) begin
          tick();
          if (oe === 4'b0000) gap++;
          n++;
        end
        checks++;
        if (gap != TURN_CYC + 1) begin
          errors++;
          $display("FAIL rr_gap g=%0d gap=%0d required=%0d", g, gap, TURN_CYC + 1);
        end
      end
    end
    drain();
    checks++;
    if (tmo_cnt != 0) begin
      errors++;
      $display("FAIL rr_timeout pulses=%0d required=0", tmo_cnt);
    end
  endtask

  task automatic test_timeout();
    int hi;
    int n;
    do_reset();
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0010);
    req = 4'b0010;
    tick();
    hi = (oe === 4'b0010) ? 1 : 0;
    n = 0;
    while (oe === 4'b0010 && n < 40) begin
      tick();
      if (oe === 4'b0010) hi++;
      n++;
    end
    checks++;
    if (hi != MAX_HOLD) begin
      errors++;
      $display("FAIL timeout_hold cycles=%0d required=%0d", hi, MAX_HOLD);
    end
    checks++;
    if (oe !== 4'b0000 || hold_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse oe=%b tmo=%b required oe=0000 tmo=1", oe, hold_timeout);
    end
    tick();
    checks++;
    if (hold_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width tmo=%b required=0", hold_timeout);
    end
    tick();
    checks++;
    if (oe !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_regrant oe=%b required=0010", oe);
    end
    drain();
    checks++;
    if (tmo_cnt != 1) begin
      errors++;
      $display("FAIL timeout_count pulses=%0d required=1", tmo_cnt);
    end
  endtask

  task automatic test_timeout_done();
    do_reset();
    exp_q.push_back(4'b0010);
    req = 4'b0010;
    tick();
    repeat (MAX_HOLD - 1) tick();
    checks++;
    if (oe !== 4'b0010) begin
      errors++;
      $display("FAIL tdone_last_cycle oe=%b required=0010", oe);
    end
    done = 4'b0010;
    tick();
    done = 4'b0000;
    req  = 4'b0000;
    checks++;
    if (oe !== 4'b0000 || hold_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tdone_release oe=%b tmo=%b required oe=0000 tmo=0", oe, hold_timeout);
    end
    drain();
    checks++;
    if (tmo_cnt != 0) begin
      errors++;
      $display("FAIL tdone_count pulses=%0d required=0", tmo_cnt);
    end
  endtask

  task automatic test_non_owner();
    do_reset();
    exp_q.push_back(4'b0001);
    req = 4'b1001;
    tick();
    for (int i = 0; i < 8; i++) begin
      done   = 4'b0100;
      req[3] = ~req[3];
      tick();
      checks++;
      if (oe !== 4'b0001 || owner !== 2'd0) begin
        errors++;
        $display("FAIL non_owner i=%0d oe=%b owner=%0d required oe=0001 owner=0", i, oe, owner);
      end
    end
    done = 4'b0001;
    req  = 4'b0000;
    tick();
    checks++;
    if (oe !== 4'b0000) begin
      errors++;
      $display("FAIL non_owner_release oe=%b required=0000", oe);
    end
    drain();
  endtask

  task automatic test_random();
    sb_en = 1'b0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      done = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      rst  = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;
    drain();
    sb_en = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    tmo_cnt = 0;
    sb_en   = 1'b1;
    rst     = 1'b1;
    req     = 4'b0000;
    done    = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_timeout_done();
    test_non_owner();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Sequential controller that shares one tristate bus among N_REQ requesters.
- Each requester drives the bus through its own bufif1 cell. This block produces the one-hot output-enables for those cells.
- Guarantees that no two drivers overlap. A dead (turnaround) period is inserted between owners, during which the bus pullup holds the line.
- Ownership is granted round-robin, and a hold-time limit stops any requester from monopolising the bus.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- MAX_HOLD, 16, maximum consecutive cycles one owner may drive (>=2).
- TURN_CYC, 1, dead cycles with all enables low between owners (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  N_REQ  per-requester bus request, level-sensitive.
- done  input  N_REQ  per-requester release strobe; only the current owner's bit is honoured.
- grant  output  N_REQ  one-hot ownership; registered.
- oe  output  N_REQ  one-hot enable to the requester's bufif1 control; registered.
- owner  output  $clog2(N_REQ)  index of the current owner; holds the last value when not driving.
- bus_idle  output  1  high when all oe are low (bus floats to pullup).
- hold_timeout  output  1  one-cycle pulse when an owner is evicted by MAX_HOLD.

Behaviour:
- Reset: the following take effect on the next clk edge while rst=1, and rst overrides everything, including mid-ownership:
  - grant=0, oe=0, owner=0, bus_idle=1, hold_timeout=0.
  - State IDLE, RR pointer=0, hold counter=0.
  - While rst is asserted, oe is low on the next edge, so the bus is released within 1 cycle.
- States: IDLE, DRIVE, TURN.
- IDLE:
  - If any req bit is set, select the winner with a round-robin search. The search starts at pointer index p and proceeds p, p+1, … wrapping modulo N_REQ.
  - Next cycle: state=DRIVE, grant[w]=oe[w]=1, owner=w, pointer=(w+1) mod N_REQ, counter=0.
  - Latency is 1 cycle from req sampled high to grant/oe high.
  - If no req is set, stay in IDLE with all outputs idle.
- DRIVE:
  - The counter increments each cycle.
  - Release when done[owner]=1, req[owner]=0, or counter==MAX_HOLD-1.
  - On release, next cycle: grant=0, oe=0, state=TURN, turnaround counter=0.
  - hold_timeout pulses high in that same next cycle only if the release was caused by the counter limit and neither done[owner] nor a dropped req[owner] occurred in the same cycle. done/req-drop has precedence, so there is no pulse.
  - done bits of non-owners are ignored.
  - The owner drives for at least 1 and at most MAX_HOLD cycles.
- TURN:
  - All enables stay low for TURN_CYC cycles, then state=IDLE.
  - Requests arriving during TURN are held, not lost, because req is level.
  - With continuous requests, the inter-grant gap is TURN_CYC+1 cycles (TURN plus the IDLE arbitration cycle).
- Fairness: a requester that holds req high is granted within (N_REQ-1) × (MAX_HOLD+TURN_CYC+1) cycles.
- Invariants:
  - grant==oe at all times.
  - $onehot0(oe) at all times.
  - No cycle exists in which oe moves directly from one nonzero value to a different nonzero value.
  - bus_idle == ~|oe.
- Simultaneous events:
  - done and a new req from another requester in the same cycle: still passes through TURN.
  - The owner re-requesting immediately after done loses priority to others because the pointer has advanced. It is regranted only if no other req is present.
- Width: the hold counter is $clog2(MAX_HOLD) bits and never wraps (it resets on each grant).

Decomposition:
- Package tristate_bus_pkg holds:
  - the state enum typedef (IDLE, DRIVE, TURN);
  - default parameter constants;
  - the function that computes index width.
- Sub-module rr_picker is purely combinational: inputs req and pointer, outputs a valid flag and the winner index. It is instantiated once.
- The FSM, counters and output registers live in tristate_bus_arbiter.

Test Plan:
- Reset mid-drive: with requester 2 owning (oe=0100), assert rst for 1 cycle. Required: oe=0000, bus_idle=1 and owner=0 on the next edge, then normal arbitration resumes with pointer=0.
- Single requester: req=0001 held, done pulsed at DRIVE cycle 3. Required:
  - grant=0001 one cycle after req;
  - oe low for exactly 1 TURN cycle;
  - regranted after the IDLE cycle;
  - hold_timeout never asserted.
- Round-robin: req=1111 held and each owner asserts done after 2 cycles. Required:
  - grant order 0001, 0010, 0100, 1000, 0001;
  - every transition passes through oe=0000 for TURN_CYC cycles.
- Timeout: req=0010 held with done never asserted, MAX_HOLD=16. Required:
  - oe[1] high for exactly 16 cycles;
  - hold_timeout pulses once on the first TURN cycle;
  - regrant follows.
- Simultaneous timeout and done: done[owner] asserted on cycle MAX_HOLD-1. Required: release happens and hold_timeout stays 0.
- Non-owner done/req drop: owner 0; done=0100 and req[3] toggles. Required: ownership is unaffected, and the checker sees $onehot0(oe) and no direct owner-to-owner switch throughout a 10k-cycle random run.
